// File: rtl/from8bit_pkg.sv
// -----------------------------------------------------------------------------
// from8bit_pkg
// Shared definitions for the byte-to-word packer:
//   - mode select constants (dataS encoding)
//   - byte-index state encoding for the packer FSM
//   - helpers: mode normalisation and final byte index per mode
// -----------------------------------------------------------------------------
package from8bit_pkg;

    localparam logic [1:0] MODE_8  = 2'b00;
    localparam logic [1:0] MODE_16 = 2'b01;
    localparam logic [1:0] MODE_32 = 2'b10;
    localparam logic [1:0] MODE_8B = 2'b11;

    // State value = index of the next byte expected within the word.
    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2,
        S_B3 = 2'd3
    } state_t;

    // 00 and 11 are both 8-bit mode; fold them so they compare equal.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == MODE_8B) ? MODE_8 : mode;
    endfunction

    // Index of the byte that completes a word in the given mode.
    function automatic state_t last_idx(input logic [1:0] mode);
        case (mode)
            MODE_16: return S_B1;
            MODE_32: return S_B3;
            default: return S_B0;
        endcase
    endfunction

endpackage

// File: rtl/from8bit_sync_det.sv
// -----------------------------------------------------------------------------
// from8bit_sync_det
// Alignment marker detector for the packer (only built with FROM8BIT_SYNC_EN).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_accept     : a byte is accepted this cycle
//   i_data       : the byte
//   i_mode       : current dataS value
//   i_partial    : packer currently holds a partial word (state != S_B0)
//   o_hit        : combinational, marker accepted in a multi-byte mode
//   o_align_err  : registered one-cycle pulse, partial word was discarded
// -----------------------------------------------------------------------------
module from8bit_sync_det
    import from8bit_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hBC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_accept,
    input  logic [7:0] i_data,
    input  logic [1:0] i_mode,
    input  logic       i_partial,
    output logic       o_hit,
    output logic       o_align_err
);

    logic r_align_err;

    // In 8-bit mode the marker is just an ordinary one-byte word.
    assign o_hit = i_accept && (i_data == SYNC_BYTE) && (norm_mode(i_mode) != MODE_8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= o_hit && i_partial;
        end
    end

    assign o_align_err = r_align_err;

endmodule

// File: rtl/from8bit_packer.sv
// -----------------------------------------------------------------------------
// from8bit_packer
// Rebuilds 8/16/32-bit words from a byte stream; first byte lands in [7:0].
// Optional marker alignment is enabled by defining FROM8BIT_SYNC_EN.
// Ports:
//   clk, rst            : base clock, synchronous active-high reset
//   enb                 : block enable (low = hold everything, accept nothing)
//   dataS               : mode 00/11 = 8-bit, 01 = 16-bit, 10 = 32-bit
//   dataIn, inValid     : input byte and its qualifier
//   dataOut8/16/32      : last completed word of each width
//   outValid            : one-cycle pulse, a word completed on the last edge
//   busy                : a partial word is held
//   dbgState            : current FSM state (next byte index)
//   alignErr            : one-cycle pulse, partial discarded by marker
//                         (present only with FROM8BIT_SYNC_EN)
// Handshake: a byte is taken on a rising edge when enb && inValid && !rst;
// there is no back-pressure, the packer accepts one byte every cycle.
// -----------------------------------------------------------------------------
module from8bit_packer
    import from8bit_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hBC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [1:0]  dataS,
    input  logic [7:0]  dataIn,
    input  logic        inValid,
    output logic [7:0]  dataOut8,
    output logic [15:0] dataOut16,
    output logic [31:0] dataOut32,
    output logic        outValid,
    output logic        busy,
    output logic [1:0]  dbgState
`ifdef FROM8BIT_SYNC_EN
    ,
    output logic        alignErr
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_idx;
    logic [1:0]  r_mode;
    logic [23:0] r_lanes;
    logic [7:0]  r_out8;
    logic [15:0] r_out16;
    logic [31:0] r_out32;
    logic        r_valid;
    logic        r_busy;
    logic        w_accept;
    logic        w_mode_chg;
    logic        w_sync_hit;
    logic        w_complete;

    assign w_accept   = enb && inValid;
    assign w_mode_chg = (norm_mode(dataS) != norm_mode(r_mode)) && (r_state != S_B0);

`ifdef FROM8BIT_SYNC_EN
    from8bit_sync_det #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_sync_det (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_accept),
        .i_data      (dataIn),
        .i_mode      (dataS),
        .i_partial   (r_state != S_B0),
        .o_hit       (w_sync_hit),
        .o_align_err (alignErr)
    );
`else
    // Marker detection compiled out; the masked compare keeps the parameter read.
    assign w_sync_hit = 1'b0 & (dataIn == SYNC_BYTE);
`endif

    // FSM next state. A mode change or a marker restarts the word, so the
    // current byte is treated as byte 0 and any partial word is dropped.
    always_comb begin
        w_idx       = r_state;
        w_complete  = 1'b0;
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_mode_chg || w_sync_hit) begin
                w_idx = S_B0;
            end
            w_complete  = (w_idx == last_idx(dataS));
            w_state_nxt = w_complete ? S_B0 : state_t'(w_idx + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: the final byte of a word comes straight from dataIn, so only
    // lanes 0..2 need storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MODE_8;
            r_lanes <= '0;
            r_out8  <= '0;
            r_out16 <= '0;
            r_out32 <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_complete;
            r_busy  <= (w_state_nxt != S_B0);
            if (w_accept) begin
                r_mode <= dataS;
                case (w_idx)
                    S_B0:    r_lanes[7:0]   <= dataIn;
                    S_B1:    r_lanes[15:8]  <= dataIn;
                    S_B2:    r_lanes[23:16] <= dataIn;
                    default: ;
                endcase
            end
            if (w_complete) begin
                case (norm_mode(dataS))
                    MODE_16: r_out16 <= {dataIn, r_lanes[7:0]};
                    MODE_32: r_out32 <= {dataIn, r_lanes[23:0]};
                    default: r_out8  <= dataIn;
                endcase
            end
        end
    end

    assign dataOut8  = r_out8;
    assign dataOut16 = r_out16;
    assign dataOut32 = r_out32;
    assign outValid  = r_valid;
    assign busy      = r_busy;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_from8bit_packer.sv
module tb_from8bit_packer;

    localparam logic [7:0] SYNC = 8'hBC;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        inValid;
    logic [1:0]  dataS;
    logic [7:0]  dataIn;
    logic [7:0]  dataOut8;
    logic [15:0] dataOut16;
    logic [31:0] dataOut32;
    logic        outValid;
    logic        busy;
    logic [1:0]  dbgState;
`ifdef FROM8BIT_SYNC_EN
    logic        alignErr;
`endif

    always #5 clk = ~clk;

    from8bit_packer #(.SYNC_BYTE(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .dataS     (dataS),
        .dataIn    (dataIn),
        .inValid   (inValid),
        .dataOut8  (dataOut8),
        .dataOut16 (dataOut16),
        .dataOut32 (dataOut32),
        .outValid  (outValid),
        .busy      (busy),
        .dbgState  (dbgState)
`ifdef FROM8BIT_SYNC_EN
        ,
        .alignErr  (alignErr)
`endif
    );

    // ---------------- reference model ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  part_q[$];
    logic [31:0] exp_q[$];
    int          exp_w_q[$];
    logic [1:0]  m_mode = 2'b00;
    logic [7:0]  exp8   = '0;
    logic [15:0] exp16  = '0;
    logic [31:0] exp32  = '0;
    logic        exp_valid = 1'b0;
    logic        exp_align = 1'b0;

    function automatic int wbytes(input logic [1:0] m);
        if (m == 2'b01) return 2;
        if (m == 2'b10) return 4;
        return 1;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic v,
                              input logic [1:0] m, input logic [7:0] d);
        logic        had;
        logic [31:0] word;
        exp_valid = 1'b0;
        exp_align = 1'b0;
        if (r) begin
            part_q.delete();
            m_mode = 2'b00;
            exp8 = '0;
            exp16 = '0;
            exp32 = '0;
        end else if (e && v) begin
            had = (part_q.size() != 0);
            if (had && wbytes(m) != wbytes(m_mode)) part_q.delete();
`ifdef FROM8BIT_SYNC_EN
            if (d == SYNC && wbytes(m) != 1) begin
                exp_align = had;
                part_q.delete();
            end
`endif
            part_q.push_back(d);
            m_mode = m;
            if (part_q.size() == wbytes(m)) begin
                word = '0;
                foreach (part_q[i]) word = word | (32'(part_q[i]) << (8 * i));
                case (wbytes(m))
                    2:       exp16 = word[15:0];
                    4:       exp32 = word;
                    default: exp8  = word[7:0];
                endcase
                exp_valid = 1'b1;
                exp_q.push_back(word);
                exp_w_q.push_back(wbytes(m));
                part_q.delete();
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] w;
        int          wb;
        chk("outValid", 32'(outValid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(part_q.size() != 0));
        chk("state", 32'(dbgState), 32'(part_q.size()));
        chk("dataOut8", 32'(dataOut8), 32'(exp8));
        chk("dataOut16", 32'(dataOut16), 32'(exp16));
        chk("dataOut32", dataOut32, exp32);
`ifdef FROM8BIT_SYNC_EN
        chk("alignErr", 32'(alignErr), 32'(exp_align));
`endif
        // Scoreboard: every pulse must match the oldest expected word.
        if (outValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pulse", 32'(outValid), 32'd0);
            end else begin
                w  = exp_q.pop_front();
                wb = exp_w_q.pop_front();
                case (wb)
                    2:       chk("sb_word16", 32'(dataOut16), w);
                    4:       chk("sb_word32", dataOut32, w);
                    default: chk("sb_word8", 32'(dataOut8), w);
                endcase
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [1:0] m, input logic [7:0] d);
        rst = r;
        enb = e;
        inValid = v;
        dataS = m;
        dataIn = d;
        @(posedge clk);
        model_edge(r, e, v, m, d);
        #1;
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] cur_m;
        rst = 1'b1; enb = 1'b0; inValid = 1'b0; dataS = 2'b00; dataIn = 8'h00;

        // Reset
        step(1, 0, 0, 2'b00, 8'h00);
        step(1, 1, 1, 2'b10, 8'h55);
        chk("rst_out32", dataOut32, 32'h0);
        chk("rst_valid", 32'(outValid), 32'd0);

        // 16-bit word 34,12
        step(0, 1, 1, 2'b01, 8'h34);
        step(0, 1, 1, 2'b01, 8'h12);
        chk("tp16_word", 32'(dataOut16), 32'h1234);
        chk("tp16_pulse", 32'(outValid), 32'd1);
        chk("tp16_out8_zero", 32'(dataOut8), 32'h0);
        step(0, 1, 0, 2'b01, 8'h00);

        // 32-bit word with a one-cycle inValid gap
        step(0, 1, 1, 2'b10, 8'h78);
        step(0, 1, 1, 2'b10, 8'h56);
        step(0, 1, 0, 2'b10, 8'hEE);
        chk("tp32_gap_busy", 32'(busy), 32'd1);
        step(0, 1, 1, 2'b10, 8'h34);
        step(0, 1, 1, 2'b10, 8'h12);
        chk("tp32_word", dataOut32, 32'h12345678);
        step(0, 1, 0, 2'b10, 8'h00);

        // Mode change mid-word
        step(0, 1, 1, 2'b10, 8'hAA);
        step(0, 1, 1, 2'b10, 8'hBB);
        step(0, 1, 1, 2'b01, 8'hCD);
        step(0, 1, 1, 2'b01, 8'hAB);
        chk("tpmc_word16", 32'(dataOut16), 32'hABCD);
        chk("tpmc_no32", dataOut32, 32'h12345678);

        // enb low for 3 cycles mid-word
        step(0, 1, 1, 2'b01, 8'h11);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b01, 8'h99);
        step(0, 1, 1, 2'b01, 8'h22);
        chk("tpenb_word16", 32'(dataOut16), 32'h2211);

        // Reset mid-word
        step(0, 1, 1, 2'b10, 8'h42);
        step(1, 1, 1, 2'b10, 8'h43);
        chk("tprst_out16", 32'(dataOut16), 32'h0);
        step(0, 1, 0, 2'b10, 8'h00);
        chk("tprst_nopulse", 32'(outValid), 32'd0);

        // 8-bit mode via 11, back-to-back
        step(0, 1, 1, 2'b11, 8'h01);
        step(0, 1, 1, 2'b11, 8'h02);
        step(0, 1, 1, 2'b11, 8'h03);
        chk("tp8_last", 32'(dataOut8), 32'h03);
        step(0, 1, 0, 2'b11, 8'h00);

`ifdef FROM8BIT_SYNC_EN
        // Marker realigns a 32-bit word
        step(0, 1, 1, 2'b10, 8'h11);
        step(0, 1, 1, 2'b10, 8'h22);
        step(0, 1, 1, 2'b10, SYNC);
        chk("tpsync_align", 32'(alignErr), 32'd1);
        step(0, 1, 1, 2'b10, 8'h01);
        step(0, 1, 1, 2'b10, 8'h02);
        step(0, 1, 1, 2'b10, 8'h03);
        chk("tpsync_word32", dataOut32, 32'h030201BC);
`endif

        // Randomized traffic
        cur_m = 2'b10;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) cur_m = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) != 0),
                 cur_m,
                 ($urandom_range(0, 15) == 0) ? SYNC : 8'($urandom_range(0, 255)));
        end
        step(0, 1, 0, cur_m, 8'h00);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
